// File: rtl/layer_stream_bridge_pkg.sv
// layer_stream_bridge_pkg: NN datapath constants, bridge state type and index-width helper
package layer_stream_bridge_pkg;
    localparam int DATA_WIDTH_C = 16;
    localparam int NUM_NEURON_LAYER1 = 30;
    localparam int NUM_NEURON_LAYER2 = 30;
    localparam int NUM_NEURON_LAYER3 = 10;
    localparam int NUM_NEURON_LAYER4 = 10;
    localparam int SIGMOID_SIZE = 5;
    typedef enum logic {ST_IDLE, ST_SEND} state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/layer_stream_bridge_if.sv
// layer_stream_bridge_if: vector capture side, serial beat stream and overflow status of the bridge
interface layer_stream_bridge_if import layer_stream_bridge_pkg::*; #(
    parameter int NUM_NEURON = NUM_NEURON_LAYER1,
    parameter int DATA_WIDTH = DATA_WIDTH_C,
    parameter int DROP_CNT_W = 8
) ();
    localparam int IW = idx_w(NUM_NEURON);
    logic                             in_valid;
    logic [NUM_NEURON*DATA_WIDTH-1:0] in_data;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_last;
    logic [IW-1:0]                    out_index;
    logic                             busy;
    logic                             overflow;
    logic                             overflow_clr;
    logic [DROP_CNT_W-1:0]            drop_count;
    modport slave (
        input  in_valid, in_data, out_ready, overflow_clr,
        output out_valid, out_data, out_last, out_index, busy, overflow, drop_count
    );
    modport master (
        output in_valid, in_data, out_ready, overflow_clr,
        input  out_valid, out_data, out_last, out_index, busy, overflow, drop_count
    );
endinterface

// File: rtl/layer_stream_bridge_slot_buf.sv
// layer_stream_bridge_slot_buf: two-entry ping-pong vector store with pointers and occupancy
module layer_stream_bridge_slot_buf #(
    parameter int VEC_W = 480
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [VEC_W-1:0] i_wr_data,
    input  logic             i_rd_free,
    output logic [VEC_W-1:0] o_rd_data,
    output logic [1:0]       o_occ
);
    logic [VEC_W-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_occ;
    // A write while full is only issued alongside a free, so it reuses the slot being released
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (i_wr_en) begin
                r_mem[r_wptr] <= i_wr_data;
                r_wptr        <= ~r_wptr;
            end
            if (i_rd_free) r_rptr <= ~r_rptr;
            r_occ <= r_occ + 2'(i_wr_en) - 2'(i_rd_free);
        end
    end
    assign o_rd_data = r_mem[r_rptr];
    assign o_occ     = r_occ;
endmodule

// File: rtl/layer_stream_bridge.sv
// layer_stream_bridge: captures a parallel neuron vector into ping-pong slots and
// serialises it as a valid/ready beat stream with last marker and drop accounting
module layer_stream_bridge import layer_stream_bridge_pkg::*; #(
    parameter int NUM_NEURON = NUM_NEURON_LAYER1,
    parameter int DATA_WIDTH = DATA_WIDTH_C,
    parameter bit MSB_FIRST  = 1'b0,
    parameter int DROP_CNT_W = 8
) (
    input logic                  aclk,
    input logic                  reset,
    layer_stream_bridge_if.slave bus
);
    localparam int            IW   = idx_w(NUM_NEURON);
    localparam logic [IW-1:0] LAST = IW'(NUM_NEURON - 1);
    state_t                           r_state;
    state_t                           w_next;
    logic [IW-1:0]                    r_cnt;
    logic [IW-1:0]                    w_idx;
    logic [NUM_NEURON*DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]                       w_occ;
    logic                             w_send;
    logic                             w_xfer;
    logic                             w_release;
    logic                             w_accept;
    logic                             w_drop;
    logic                             r_overflow;
    logic [DROP_CNT_W-1:0]            r_drop_cnt;
    assign w_send    = r_state == ST_SEND;
    assign w_xfer    = w_send && bus.out_ready;
    assign w_release = w_xfer && r_cnt == LAST;
    // A last-beat release frees a slot in time for a same-cycle capture
    assign w_accept  = bus.in_valid && (w_occ != 2'd2 || w_release);
    assign w_drop    = bus.in_valid && !w_accept;
    assign w_idx     = MSB_FIRST ? LAST - r_cnt : r_cnt;
    layer_stream_bridge_slot_buf #(.VEC_W(NUM_NEURON*DATA_WIDTH)) u_slots (
        .aclk      (aclk),
        .reset     (reset),
        .i_wr_en   (w_accept),
        .i_wr_data (bus.in_data),
        .i_rd_free (w_release),
        .o_rd_data (w_rd_data),
        .o_occ     (w_occ)
    );
    always_ff @(posedge aclk) begin
        if (reset) r_state <= ST_IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == ST_IDLE) ? ((w_occ != 2'd0) ? ST_SEND : ST_IDLE)
                                      : ((w_release && w_occ == 2'd1 && !w_accept) ? ST_IDLE : ST_SEND);
    end
    always_comb begin
        bus.out_valid  = w_send;
        bus.out_last   = w_send && r_cnt == LAST;
        bus.out_index  = w_send ? w_idx : '0;
        bus.out_data   = w_rd_data[w_idx*DATA_WIDTH +: DATA_WIDTH];
        bus.busy       = w_occ != 2'd0;
        bus.overflow   = r_overflow;
        bus.drop_count = r_drop_cnt;
    end
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_xfer) r_cnt <= w_release ? '0 : r_cnt + 1'b1;
            if (bus.overflow_clr) begin
                r_overflow <= w_drop;
                r_drop_cnt <= DROP_CNT_W'(w_drop);
            end else if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= (&r_drop_cnt) ? r_drop_cnt : r_drop_cnt + 1'b1;
            end
        end
    end
endmodule
